rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Writeback arbiter directly upstream of the register-file write port. Merges two result producers onto the single RF write port (write enable, rd, write data).
- Port A is the in-order main pipeline. It has priority and no ready signal.
- Port B is the long-latency path (divider, load return). B results are buffered in a FIFO and drained into free write slots.
- A starvation guard stalls port A for one cycle so that B cannot wait forever.

Parameters:
- WORD, 32, data width.
- REG_LOG, 5, register index width.
- FIFO_DEPTH, 4, port-B buffer entries; power of two, at least 2.
- STARVE_LIMIT, 8, cycles a non-empty FIFO head may wait before port A is stalled; at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  main-pipeline result valid.
- a_rd  in  REG_LOG  main-pipeline destination register.
- a_data  in  WORD  main-pipeline result.
- b_valid  in  1  long-latency result valid.
- b_ready  out  1  FIFO can accept a result.
- b_rd  in  REG_LOG  long-latency destination register.
- b_data  in  WORD  long-latency result.
- stall_a  out  1  main pipeline must hold a_valid low this cycle.
- rf_we  out  1  registered RF write enable.
- rf_rd  out  REG_LOG  registered RF destination.
- rf_wdata  out  WORD  registered RF write data.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, synchronous, takes precedence over all other activity:
  - rf_we, rf_rd, rf_wdata = 0.
  - FIFO emptied; fifo_count = 0.
  - Starve counter = 0; state = NORMAL.
  - stall_a = 0; b_ready = 1 in the first cycle after reset.
- Reset during operation: buffered B results are discarded; rf_we = 0 on the next cycle.
- b_ready = (fifo_count != FIFO_DEPTH).
  - b_ready is computed from the registered count, not from a same-cycle pop. When the FIFO is full, b_ready = 0 even if the FIFO pops that cycle.
- Port B push: b_valid && b_ready.
  - If b_rd == 0, the result is accepted and dropped (never enqueued).
- Slot selection each cycle, priority order:
  - a_valid && a_rd != 0 → write A.
  - Otherwise, if the FIFO is non-empty → pop the head and write it.
  - Otherwise → rf_we = 0 next cycle.
- Port A with a_rd == 0 never writes; the slot counts as free and the FIFO may drain.
- Latency: selected write appears on rf_we/rf_rd/rf_wdata at the next posedge (1 cycle). The RF commits on the following negedge.
- A simultaneous push and pop in one cycle leaves fifo_count unchanged. Pop order is FIFO.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Starve counter:
  - +1 each cycle the FIFO is non-empty and no pop occurs.
  - Cleared on any pop or when the FIFO is empty.
- State machine:
  - NORMAL → FORCE when the counter reaches STARVE_LIMIT.
  - In FORCE: stall_a = 1, the head pops, the counter clears, and the next state is NORMAL. FORCE lasts exactly one cycle.
- Protocol violation: a_valid high while stall_a = 1. Port A still wins the slot, and a simulation-only assertion fires.
- WAW ordering between A and B to the same rd is the issue logic's responsibility (scoreboard); this block does no ordering check.

Optional Feature:
- Macro: RF_WB_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits, cleared by rst.
  - Increments on each FORCE cycle and saturates at 32'hFFFFFFFF.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Shared CPU parameter header supplies WORD and REG_LOG widths and the FSM state encodings (NORMAL = 1'b0, FORCE = 1'b1).
- One natural sub-module: rf_wb_fifo, a synchronous FIFO with push/pop/count/full/empty. It is instantiated once for port B.
- The arbiter, starve counter and FSM stay in the top level.

Test Plan:
- Reset then idle: rf_we = 0, b_ready = 1, fifo_count = 0, stall_a = 0 for 5 cycles.
- Single B result (rd = 3, data = 32'hDEAD_BEEF) with a_valid = 0: one cycle later rf_we = 1, rf_rd = 3, rf_wdata = 32'hDEAD_BEEF; fifo_count back to 0.
- Collision: A (rd = 5, 32'h11) and B (rd = 6, 32'h22) in the same cycle → A written first, B written in the next free cycle. A with rd = 0 lets B drain in that same cycle.
- Fill: 4 B pushes while A is busy every cycle → b_ready = 0 at fifo_count = 4. A fifth b_valid is held and not accepted.
- Starvation: FIFO non-empty with A busy continuously → stall_a pulses high for one cycle after 8 waiting cycles. The head is written that cycle; with RF_WB_STALL_CNT_EN defined, stall_cnt = 1.
- Reset with 3 entries queued → fifo_count = 0 and rf_we = 0 the next cycle; none of the queued data is ever written.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and FSM encodings for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   localparam int WORD_W    = 32;
   localparam int REG_LOG_W = 5;

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } wb_state_e;

   // Bits needed to hold values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO buffering long-latency results ahead of the RF write port.
module rf_wb_fifo #(
   parameter int DW    = 37,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges the in-order pipeline (A) and buffered long-latency results (B) onto one RF write port.
// Optional RF_WB_STALL_CNT_EN adds a saturating count of starvation-forced stall cycles.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int WORD         = WORD_W,
   parameter int REG_LOG      = REG_LOG_W,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          a_valid,
   input  logic [REG_LOG-1:0]            a_rd,
   input  logic [WORD-1:0]               a_data,
   input  logic                          b_valid,
   output logic                          b_ready,
   input  logic [REG_LOG-1:0]            b_rd,
   input  logic [WORD-1:0]               b_data,
   output logic                          stall_a,
   output logic                          rf_we,
   output logic [REG_LOG-1:0]            rf_rd,
   output logic [WORD-1:0]               rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef RF_WB_STALL_CNT_EN
   ,
   output logic [31:0]                   stall_cnt
`endif
);

   localparam int EW = REG_LOG + WORD;
   localparam int SW = cnt_w(STARVE_LIMIT);

   wb_state_e       state;
   logic [SW-1:0]   starve_cnt, starve_nxt;
   logic [EW-1:0]   head;
   logic            fifo_full, fifo_empty;
   logic            a_win, pop, push;

   // b_ready follows the registered occupancy, so a full FIFO refuses even when it pops.
   assign b_ready    = !fifo_full;
   assign a_win      = a_valid && (a_rd != '0);
   assign pop        = !a_win && !fifo_empty;
   assign push       = b_valid && b_ready && (b_rd != '0);
   assign starve_nxt = starve_cnt + 1'b1;

   rf_wb_fifo #(
      .DW    (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({b_rd, b_data}),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= a_win || pop;
         if (a_win) begin
            rf_rd    <= a_rd;
            rf_wdata <= a_data;
         end else if (pop) begin
            {rf_rd, rf_wdata} <= head;
         end
      end
   end

   // FORCE only holds A off; the head then wins the free slot through normal selection.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= NORMAL;
         stall_a    <= 1'b0;
         starve_cnt <= '0;
      end else begin
         case (state)
            NORMAL: begin
               if (fifo_empty || pop) begin
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= starve_nxt;
                  if (starve_nxt == SW'(STARVE_LIMIT)) begin
                     state   <= FORCE;
                     stall_a <= 1'b1;
                  end
               end
            end
            FORCE: begin
               state      <= NORMAL;
               stall_a    <= 1'b0;
               starve_cnt <= '0;
            end
            default: begin
               state      <= NORMAL;
               stall_a    <= 1'b0;
               starve_cnt <= '0;
            end
         endcase
      end
   end

`ifdef RF_WB_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (state == FORCE && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

`ifndef SYNTHESIS
   a_no_valid_in_stall: assert property (@(posedge clk) disable iff (rst) !(a_valid && stall_a));
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then randomized traffic vs. a queue model.
module tb_rf_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [4:0]  a_rd = '0, b_rd = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic        b_ready, stall_a, rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [2:0]  fifo_count;
`ifdef RF_WB_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   rf_wb_arbiter #(.WORD(32), .REG_LOG(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_rd       (a_rd),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_rd       (b_rd),
      .b_data     (b_data),
      .stall_a    (stall_a),
      .rf_we      (rf_we),
      .rf_rd      (rf_rd),
      .rf_wdata   (rf_wdata),
      .fifo_count (fifo_count)
`ifdef RF_WB_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] cnt;
      logic        stall;
      logic [31:0] sc;
   } exp_t;

   exp_t          exp_q[$];
   logic [36:0]   bq[$];        // model of buffered B results {rd, data}
   int            m_wait = 0;
   logic          m_force = 1'b0;
   logic [31:0]   m_sc = '0;
   int            n_chk = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model predicts what the outputs show after the next edge.
   task automatic step(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
      exp_t        e;
      logic        nonempty, ready, popped;
      logic [36:0] h;
      @(posedge clk); #1;
      if (m_force) av = 1'b0;
      rst = r; a_valid = av; a_rd = ar; a_data = ad;
      b_valid = bv; b_rd = br; b_data = bd;
      e = '0;
      if (r) begin
         bq.delete(); m_wait = 0; m_force = 1'b0; m_sc = '0;
      end else begin
         nonempty = (bq.size() != 0);
         ready    = (bq.size() < DEPTH);
         popped   = 1'b0;
         if (av && ar != 0) begin
            e.we = 1'b1; e.rd = ar; e.data = ad;
         end else if (nonempty) begin
            h = bq.pop_front();
            e.we = 1'b1; e.rd = h[36:32]; e.data = h[31:0];
            popped = 1'b1;
         end
         if (bv && ready && br != 0) bq.push_back({br, bd});
         if (m_force) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc++;
            m_force = 1'b0; m_wait = 0;
         end else if (!nonempty || popped) begin
            m_wait = 0;
         end else begin
            m_wait++;
            if (m_wait == LIMIT) m_force = 1'b1;
         end
      end
      e.cnt = bq.size(); e.stall = m_force; e.sc = m_sc;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: the entry pushed one cycle earlier describes the outputs now visible.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #3;
         if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e.we));
            if (e.we) begin
               chk("rf_rd", 32'(rf_rd), 32'(e.rd));
               chk("rf_wdata", rf_wdata, e.data);
            end
            chk("fifo_count", 32'(fifo_count), e.cnt);
            chk("b_ready", 32'(b_ready), 32'(e.cnt != DEPTH));
            chk("stall_a", 32'(stall_a), 32'(e.stall));
`ifdef RF_WB_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, e.sc);
`endif
         end
      end
   end

   initial begin
      int pa;
      logic [4:0] ar, br;
      // reset then idle
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(5);
      // single B result
      step(0, 0, 0, 0, 1, 5'd3, 32'hDEAD_BEEF);
      idle(3);
      // collision: A first, B next free slot
      step(0, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
      idle(2);
      // A with rd 0 lets a queued B drain in that cycle
      step(0, 1, 5'd9, 32'h99, 1, 5'd8, 32'h44);
      step(0, 1, 5'd0, 32'h55, 0, 0, 0);
      idle(2);
      // fill with A busy, hold a fifth B, keep A busy until starvation forces a drain
      for (int i = 0; i < 16; i++)
         step(0, 1, 5'd10 + 5'(i % 4), 32'hA000 + i, 1, 5'd20 + 5'(i % 5), 32'hB000 + i);
      idle(8);
      // B with rd 0 is accepted and dropped
      step(0, 0, 0, 0, 1, 5'd0, 32'hBAD);
      idle(2);
      // reset with three entries queued
      for (int i = 0; i < 3; i++) step(0, 1, 5'd1, 32'hC0 + i, 1, 5'd2, 32'hD0 + i);
      step(1, 1, 5'd1, 32'hC9, 0, 0, 0);
      idle(4);
      // randomized traffic, alternating light and heavy A load
      for (int i = 0; i < 3000; i++) begin
         pa = ((i / 400) % 2 == 1) ? 95 : 50;
         ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         br = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         step(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < pa), ar, $urandom,
              ($urandom_range(0, 99) < 40), br, $urandom);
      end
      idle(10);
      @(posedge clk); @(posedge clk); #5;
      chk("sb_drain", exp_q.size(), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
